// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: one payload word per cycle, 1-cycle latency, valid/ready on both sides.
// Two-entry skid keeps in_ready and out_valid register-driven; flush squashes both entries.
module pipe_skid_stage #(
  parameter int                    data_width  = 32,
  parameter logic [data_width-1:0] reset_value = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_data,
  output logic [1:0]            occupancy
);

  logic                  main_valid;
  logic [data_width-1:0] main_data;
  logic                  skid_valid;
  logic [data_width-1:0] skid_data;

  logic push;
  logic pop;

  assign push = in_valid && !skid_valid;
  assign pop  = main_valid && out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign in_ready  = !skid_valid;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  // skid_valid only ever rises while main_valid is held, so the valid
  // pair encodes EMPTY/ONE/FULL directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= reset_value;
      skid_data  <= reset_value;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid) begin
      if (push) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end
    end else if (!skid_valid) begin
      if (push && pop) begin
        main_data <= in_data;
      end else if (push) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end else if (pop) begin
        main_valid <= 1'b0;
      end
    end else if (pop) begin
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus randomized valid/ready/flush
// traffic, all checked against a two-slot FIFO queue model.
module tb_pipe_skid_stage;

  localparam int         dw = 8;
  localparam logic [7:0] rv = 8'h5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [dw-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [dw-1:0] out_data;
  logic [1:0]    occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [dw-1:0] mq[$];

  pipe_skid_stage #(.data_width(dw), .reset_value(rv)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    chk("occupancy", {30'd0, occupancy}, mq.size());
    if (mq.size() > 0) chk("out_data", {24'd0, out_data}, {24'd0, mq[0]});
  endtask

  // Stage behaves as a 2-deep FIFO whose accept decision uses the pre-edge fill level.
  task automatic model_step();
    int sz;
    sz = mq.size();
    if (flush) begin
      mq.delete();
    end else begin
      if (sz > 0 && out_ready) void'(mq.pop_front());
      if (in_valid && sz < 2) mq.push_back(in_data);
    end
  endtask

  task automatic tick(input bit probe = 1'b0);
    logic ir_s;
    @(negedge clk);
    check_model();
    if (probe) begin
      ir_s = in_ready;
      out_ready = ~out_ready;
      #1;
      chk("in_ready_indep", {31'd0, in_ready}, {31'd0, ir_s});
      out_ready = ~out_ready;
      #1;
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, {24'd0, rv});
    rst = 1'b0;
    mq.delete();

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = dw'(i);
      tick();
      chk("stream_data", {24'd0, out_data}, i);
      chk("stream_occ", {30'd0, occupancy}, 32'd1);
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();

    // Stall fill then drain
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h0A; tick();
    chk("fill_occ1", {30'd0, occupancy}, 32'd1);
    in_data = 8'h0B; tick();
    chk("fill_occ2", {30'd0, occupancy}, 32'd2);
    chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("drain_data_b", {24'd0, out_data}, 32'h0B);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("drain_occ0", {30'd0, occupancy}, 32'd0);

    // Push and pop together while holding one entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h05; tick();
    out_ready = 1'b1; in_data = 8'h06; tick();
    chk("pp_data", {24'd0, out_data}, 32'h06);
    chk("pp_occ", {30'd0, occupancy}, 32'd1);
    in_valid = 1'b0; tick();

    // Flush while full with a simultaneous in_valid
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h0A; tick();
    in_data = 8'h0B; tick();
    flush = 1'b1; in_data = 8'h0C; tick();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_occ", {30'd0, occupancy}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0; in_data = 8'h07; tick();
    chk("post_flush_data", {24'd0, out_data}, 32'h07);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("post_flush_empty", {30'd0, occupancy}, 32'd0);

    // Asynchronous reset between edges while full
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_out_data", {24'd0, out_data}, {24'd0, rv});
    chk("arst_occ", {30'd0, occupancy}, 32'd0);
    rst = 1'b0;
    mq.delete();

    // Randomized traffic
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      flush     = ($urandom_range(0, 99) < 3);
      tick((c % 8) == 0);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk("final_empty", {30'd0, occupancy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
